prbs_15_rx_checker: RTL

Receive-side companion to the PRBS-15 transmitter. It hunts for a programmed 32-bit pattern in the serial bit stream and confirms it repeats n times back-to-back. It then locks onto the transmitter's PRBS-15 byte stream and checks every byte against a locally mirrored LFSR. It sits at the link sink and reports detection, lock and per-byte errors to the test controller.

---
 rtl/prbs_pkg.sv | 21 ++
 rtl/prbs15_lfsr.sv | 22 ++
 rtl/prbs_15_rx_checker.sv | 135 +++++++++++++
 3 files changed

// File: rtl/prbs_pkg.sv
// Shared PRBS-15 definitions for the link transmitter and receiver.
// Seed, checker states, LFSR step and byte mapping.
package prbs_pkg;

    localparam logic [14:0] PRBS15_SEED = 15'h7FFF;

    typedef enum logic [1:0] {
        HUNT,
        TRACK,
        PRBS_CHECK
    } state_t;

    function automatic logic [14:0] prbs15_next(input logic [14:0] s);
        return {s[13:0], s[13] ^ s[14]};
    endfunction

    function automatic logic [7:0] prbs15_byte(input logic [14:0] s);
        return {s[6:0], s[14]};
    endfunction

endpackage

// File: rtl/prbs15_lfsr.sv
// PRBS-15 LFSR, loaded with the seed on reset and stepped on enable.
// Shared between the link transmitter and the receive checker.
module prbs15_lfsr
    import prbs_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [14:0] seed,
    output logic [14:0] state
);

    // Advance one step per enabled cycle, hold otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= seed;
        end else if (enable) begin
            state <= prbs15_next(state);
        end
    end

endmodule

// File: rtl/prbs_15_rx_checker.sv
// PRBS-15 receive checker: serial pattern hunt, repetition tracking, byte check.
// Define PRBS_ERR_CNT_EN to add the saturating err_count output.
module prbs_15_rx_checker
    import prbs_pkg::*;
#(
    parameter int PAT_W = 32,
    parameter int N_W   = 3,
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_W-1:0]   n,
    input  logic [PAT_W-1:0] pattern,
    input  logic             serial_in,
    input  logic             serial_valid,
    input  logic [7:0]       data_random,
    input  logic             prbs_valid,
    output logic             seq_detected,
    output logic             locked,
    output logic             prbs_error,
`ifdef PRBS_ERR_CNT_EN
    output logic [ERR_W-1:0] err_count,
`endif
    output logic [N_W-1:0]   rep_count
);

    localparam int BW = $clog2(PAT_W);

    state_t           state;
    logic [PAT_W-2:0] sr;
    logic [BW:0]      fill;
    logic [BW-1:0]    bitcnt;
    logic [14:0]      lfsr;

    logic [PAT_W-1:0] shifted;
    logic             fill_full;
    logic             have_bits;
    logic [BW-1:0]    bit_idx;
    logic [N_W-1:0]   rep_nxt;
    logic             lfsr_en;
    logic             byte_bad;

    assign shifted   = {sr, serial_in};
    assign fill_full = (fill == (BW+1)'(PAT_W));
    assign have_bits = (fill >= (BW+1)'(PAT_W - 1));
    assign bit_idx   = BW'(PAT_W - 1) - bitcnt;
    assign rep_nxt   = rep_count + N_W'(1);
    assign lfsr_en   = (state == PRBS_CHECK) && prbs_valid;
    assign byte_bad  = lfsr_en && (data_random != prbs15_byte(lfsr));

    prbs15_lfsr u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .enable (lfsr_en),
        .seed   (PRBS15_SEED),
        .state  (lfsr)
    );

    // Hunt / track / check sequencing with registered pulse outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= HUNT;
            sr           <= '0;
            fill         <= '0;
            bitcnt       <= '0;
            rep_count    <= '0;
            seq_detected <= 1'b0;
            locked       <= 1'b0;
            prbs_error   <= 1'b0;
        end else begin
            seq_detected <= 1'b0;
            prbs_error   <= 1'b0;
            unique case (state)
                HUNT: begin
                    if (n == '0) begin
                        state  <= PRBS_CHECK;
                        locked <= 1'b1;
                    end else if (serial_valid) begin
                        sr <= shifted[PAT_W-2:0];
                        if (!fill_full) fill <= fill + 1'b1;
                        if (have_bits && shifted == pattern) begin
                            rep_count <= N_W'(1);
                            bitcnt    <= '0;
                            fill      <= '0;
                            if (n <= N_W'(1)) begin
                                seq_detected <= 1'b1;
                                locked       <= 1'b1;
                                state        <= PRBS_CHECK;
                            end else begin
                                state <= TRACK;
                            end
                        end
                    end
                end
                TRACK: begin
                    if (serial_valid) begin
                        sr <= shifted[PAT_W-2:0];
                        if (serial_in != pattern[bit_idx]) begin
                            rep_count <= '0;
                            fill      <= (BW+1)'(1);
                            state     <= HUNT;
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                            if (bitcnt == '1) begin
                                rep_count <= rep_nxt;
                                if (rep_nxt == n) begin
                                    seq_detected <= 1'b1;
                                    locked       <= 1'b1;
                                    state        <= PRBS_CHECK;
                                end
                            end
                        end
                    end
                end
                PRBS_CHECK: begin
                    locked     <= 1'b1;
                    prbs_error <= byte_bad;
                end
                default: state <= HUNT;
            endcase
        end
    end

`ifdef PRBS_ERR_CNT_EN
    // Count byte mismatches, saturating at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_count <= '0;
        end else if (byte_bad && err_count != '1) begin
            err_count <= err_count + 1'b1;
        end
    end
`endif

endmodule
